mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit with an internal HI/LO register pair, parametrised in WIDTH.
//   Sits beside the ALU and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//   A busy/done handshake lets the control unit stall the PC while an operation runs.
//   Both MFHI and MFLO read hi_out/lo_out directly.
// PARAMETERS
//   WIDTH   32   operand width; HI and LO are each WIDTH bits; WIDTH must be even and >= 4
// PORTS
//   clock       in   1        rising-edge clock
//   reset       in   1        asynchronous, active-high reset
//   start       in   1        launch op; accepted only while busy==0
//   op          in   4        operation code (mips_muldiv_pkg::MD_*)
//   src_a       in   WIDTH    rs operand: multiplicand/dividend, or MTHI/MTLO data
//   src_b       in   WIDTH    rt operand: multiplier/divisor
//   abort       in   1        flush: cancel the in-flight op, leave HI/LO unchanged
//   busy        out  1        op in progress; control unit stalls on MFHI/MFLO/start
//   done        out  1        one-cycle pulse; HI/LO were updated at this edge
//   div_by_zero out  1        registered with done; set for DIV/DIVU with src_b==0
//   hi_out      out  WIDTH    HI register
//   lo_out      out  WIDTH    LO register
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, div_by_zero=0, hi_out=0, lo_out=0; counter cleared.
//     Reset applies at any time, including mid-operation.
//   FSM states: IDLE -> MUL | DIV -> FINAL -> IDLE.
//   IDLE:
//     - start with an arithmetic op latches the operands, captures magnitudes and result sign,
//       and loads counter=WIDTH.
//     - MTHI/MTLO write src_a to HI or LO at the accepting edge, stay in IDLE,
//       and pulse done on the next cycle.
//     - Undefined op codes are ignored (no done).
//   MUL: one radix-2 shift-add step per cycle on unsigned magnitudes, 2*WIDTH-bit accumulator.
//   DIV: one restoring step per cycle; produces quotient and remainder.
//   Both loops run for WIDTH cycles, then go to FINAL.
//   FINAL applies the sign fix-up and writes HI/LO.
//     - Signed multiply: product is negated if the operand signs differ.
//     - Signed divide: quotient is negated if the operand signs differ;
//       the remainder takes the dividend's sign.
//   Latency: start accepted at edge 0; busy=1 from edge 1 to edge WIDTH+1;
//     done=1 and HI/LO updated at edge WIDTH+2, when busy also drops. For WIDTH=32 that is 34 cycles.
//   Result mapping:
//     - MULT/MULTU: {HI,LO} = product.
//     - DIV/DIVU: LO = quotient, HI = remainder.
//   Divide by zero: skip the iteration and go straight to FINAL (latency 2).
//     LO = all ones, HI = src_a, div_by_zero=1.
//   Signed overflow (DIV, src_a=MIN, src_b=-1): LO = MIN, HI = 0. No flag is raised.
//   Handshake and boundary cases:
//     - start while busy: ignored; the operation in flight is unaffected.
//     - abort while busy: return to IDLE next edge, no done, HI/LO keep their old values.
//     - abort and start in the same cycle while IDLE: abort wins and start is dropped.
//     - done and a new start in the same cycle: the new start is accepted (back-to-back).
// CONFIGURATION
//   MULDIV_ACCUM_EN defined: adds ops MADD, MADDU, MSUB, MSUBU.
//     FINAL computes {HI,LO} +/- product, with wrap-around modulo 2^(2*WIDTH).
//     Latency is the same as MULT.
//   MULDIV_ACCUM_EN undefined: those codes are treated as undefined and ignored.
// STRUCTURE
//   Shared package mips_muldiv_pkg holds:
//     - op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5,
//       MD_MADD=6, MD_MADDU=7, MD_MSUB=8, MD_MSUBU=9;
//     - the FSM state encoding: IDLE, MUL, DIV, FINAL.
//   Counter width is $clog2(WIDTH)+1.
//   Sub-module mips_div_step: combinational single restoring-division step.
//     Inputs: partial remainder, divisor, next dividend bit.
//     Outputs: new remainder, quotient bit.
// TESTING (WIDTH=32)
//   T1: MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
//   T2: MULT a=-7 b=6 -> HI=0xFFFFFFFF, LO=0xFFFFFFD6.
//       DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   T3: DIVU a=100 b=0 -> done after 2 cycles; LO=0xFFFFFFFF, HI=100, div_by_zero=1.
//       DIV a=0x80000000 b=-1 -> LO=0x80000000, HI=0.
//   T4: MULT 3*5, then start(DIV) at cycle 10 -> ignored; HI=0, LO=15.
//       abort at cycle 20 of a DIV -> no done, HI/LO keep prior values.
//   T5: assert reset mid-DIV at cycle 12 -> all outputs 0 immediately, state IDLE.
//       MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi_out=0x1234, lo_out=0x5678.
//   T6 (MULDIV_ACCUM_EN): HI:LO=0:10, MSUBU a=3 b=4 -> LO=0xFFFFFFFE, HI=0xFFFFFFFF.
//       The same op code with the macro undefined -> ignored.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: op codes and FSM states.
package mips_muldiv_pkg;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_MADD  = 4'd6;
    localparam logic [3:0] MD_MADDU = 4'd7;
    localparam logic [3:0] MD_MSUB  = 4'd8;
    localparam logic [3:0] MD_MSUBU = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FINAL
    } md_state_e;

endpackage

// File: rtl/mips_muldiv_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module mips_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        // rem_in < divisor, so whichever branch is taken fits back into WIDTH bits
        if (diff[WIDTH+1]) begin
            q_bit   = 1'b0;
            rem_out = shifted[WIDTH-1:0];
        end else begin
            q_bit   = 1'b1;
            rem_out = diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers and busy/done handshake.
// Define MULDIV_ACCUM_EN to enable MADD/MADDU/MSUB/MSUBU.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [3:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbzf_q, dbzf_d;

    logic               is_mul, is_div, is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [2*WIDTH-1:0] prod;

    // acc_q holds {partial product, multiplier} in MUL and {remainder, dividend/quotient} in DIV
    mips_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in      (acc_q[2*WIDTH-1:WIDTH]),
        .divisor     (opnd_q),
        .dividend_bit(acc_q[WIDTH-1]),
        .rem_out     (step_rem),
        .q_bit       (step_q)
    );

    always_comb begin
        is_div    = (op == MD_DIV) || (op == MD_DIVU);
`ifdef MULDIV_ACCUM_EN
        is_mul    = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
                    (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
        is_signed = (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
`else
        is_mul    = (op == MD_MULT) || (op == MD_MULTU);
        is_signed = (op == MD_MULT) || (op == MD_DIV);
`endif
        a_neg   = is_signed & src_a[WIDTH-1];
        b_neg   = is_signed & src_b[WIDTH-1];
        mag_a   = a_neg ? -src_a : src_a;
        mag_b   = b_neg ? -src_b : src_b;
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        prod    = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbzf_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (op == MD_MTHI) begin
                        hi_d   = src_a;
                        done_d = 1'b1;
                    end else if (op == MD_MTLO) begin
                        lo_d   = src_a;
                        done_d = 1'b1;
                    end else if (is_mul) begin
                        state_d = MUL;
                        busy_d  = 1'b1;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                        opnd_d  = mag_a;
                        op_d    = op;
                        neg_d   = a_neg ^ b_neg;
                    end else if (is_div) begin
                        state_d = DIV;
                        busy_d  = 1'b1;
                        op_d    = op;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        opnd_d  = mag_b;
                        // zero divisor: empty loop (counter 0) gives the two-cycle path to FINAL
                        if (src_b == '0) begin
                            dbz_d = 1'b1;
                            cnt_d = '0;
                            acc_d = {{WIDTH{1'b0}}, src_a};
                        end else begin
                            dbz_d = 1'b0;
                            cnt_d = CW'(WIDTH);
                            acc_d = {{WIDTH{1'b0}}, mag_a};
                        end
                    end
                end
            end
            MUL: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = FINAL;
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DIV: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = FINAL;
                end else begin
                    acc_d = {step_rem, acc_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FINAL: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!abort) begin
                    done_d = 1'b1;
                    case (op_q)
                        MD_MULT, MD_MULTU: {hi_d, lo_d} = prod;
                        MD_DIV, MD_DIVU: begin
                            if (dbz_q) begin
                                lo_d   = '1;
                                hi_d   = acc_q[WIDTH-1:0];
                                dbzf_d = 1'b1;
                            end else begin
                                lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                                hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                            end
                        end
`ifdef MULDIV_ACCUM_EN
                        MD_MADD, MD_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod;
                        MD_MSUB, MD_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
                        default: done_d = 1'b1;
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbzf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbzf_q  <= dbzf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbzf_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit at WIDTH=32 (MULDIV_ACCUM_EN selects T6 variant).
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        abort;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int errors = 0;
    int checks = 0;
    int cyc;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one start pulse; returns just after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (n < limit && done !== 1'b1) begin
            tick();
            n++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; abort = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dbz", div_by_zero, 0);
        check("reset_hilo", {hi_out, lo_out}, 64'h0);
        tick();
        reset = 1'b0;
        tick();

        // T1: MULTU max*max, full latency
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t1_busy", busy, 1);
        wait_done(100, cyc);
        check("t1_latency", cyc, 34);
        check("t1_busy_drop", busy, 0);
        check("t1_hilo", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);

        // T2: signed multiply, then signed divide back-to-back with done
        tick();
        issue(MD_MULT, -32'sd7, 32'sd6);
        wait_done(100, cyc);
        check("t2_mult", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFD6);
        issue(MD_DIV, -32'sd7, 32'sd2);
        check("t2_b2b_busy", busy, 1);
        wait_done(100, cyc);
        check("t2_div_lat", cyc, 34);
        check("t2_div", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        check("t2_dbz", div_by_zero, 0);
        tick();
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_done(100, cyc);
        check("divu_100_7", {hi_out, lo_out}, {32'd2, 32'd14});

        // T3: divide by zero and signed overflow
        tick();
        issue(MD_DIVU, 32'd100, 32'd0);
        wait_done(100, cyc);
        check("t3_dbz_lat", cyc, 2);
        check("t3_dbz_hilo", {hi_out, lo_out}, {32'd100, 32'hFFFF_FFFF});
        check("t3_dbz_flag", div_by_zero, 1);
        tick();
        check("t3_dbz_pulse", div_by_zero, 0);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(100, cyc);
        check("t3_ovf", {hi_out, lo_out}, {32'h0, 32'h8000_0000});
        check("t3_ovf_flag", div_by_zero, 0);

        // T4: start while busy is ignored
        tick();
        issue(MD_MULT, 32'd3, 32'd5);
        repeat (9) tick();
        issue(MD_DIV, 32'd100, 32'd3);
        wait_done(100, cyc);
        check("t4_ign_lat", cyc, 24);
        check("t4_ign_hilo", {hi_out, lo_out}, {32'd0, 32'd15});

        // T4: abort at cycle 20 of a DIV
        tick();
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (19) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_busy", busy, 0);
        wait_done(40, cyc);
        check("t4_abort_nodone", cyc, 40);
        check("t4_abort_hilo", {hi_out, lo_out}, {32'd0, 32'd15});

        // abort and start together while idle: start dropped
        abort = 1'b1;
        issue(MD_MTHI, 32'hDEAD, 32'd0);
        abort = 1'b0;
        check("idle_abort_done", done, 0);
        check("idle_abort_hi", hi_out, 32'd0);

        // T5: reset mid-DIV clears outputs immediately
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (11) tick();
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_out", {hi_out, lo_out, 1'b0}, 65'h0);
        check("t5_rst_done", {done, div_by_zero}, 2'b00);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("t5_rst_idle", {busy, done}, 2'b00);

        // T5: MTHI then MTLO on consecutive cycles
        issue(MD_MTHI, 32'h1234, 32'd0);
        check("t5_mthi_done", done, 1);
        check("t5_mthi_hi", hi_out, 32'h1234);
        issue(MD_MTLO, 32'h5678, 32'd0);
        check("t5_mtlo_done", done, 1);
        check("t5_mt_hilo", {hi_out, lo_out}, {32'h1234, 32'h5678});
        tick();
        check("t5_mt_pulse", done, 0);

        // T6: MSUBU accumulate, or ignored without the feature
        issue(MD_MTHI, 32'd0, 32'd0);
        issue(MD_MTLO, 32'd10, 32'd0);
        tick();
`ifdef MULDIV_ACCUM_EN
        issue(MD_MSUBU, 32'd3, 32'd4);
        wait_done(100, cyc);
        check("t6_msubu_lat", cyc, 34);
        check("t6_msubu", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFE);
`else
        issue(MD_MSUBU, 32'd3, 32'd4);
        check("t6_ign_busy", busy, 0);
        wait_done(40, cyc);
        check("t6_ign_nodone", cyc, 40);
        check("t6_ign_hilo", {hi_out, lo_out}, {32'd0, 32'd10});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
